fir_sample_source: RTL and testbench

Sample generator that drives the FIR filter's input stream from the board's toggle button. It debounces `toggleBtn` and walks an internal square-wave table of `DEPTH` entries. Each sample is presented on a valid/ready handshake, either one per press (step mode) or at a fixed rate (run mode). It is the producer that feeds the filter datapath, which displays results on HEX0–HEX3.

---
 rtl/fir_sample_source.sv | 153 +++++++++++++++
 tb/tb_fir_sample_source.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_source.sv
// Square-wave sample producer for the FIR datapath: debounced button press
// launches one sample (step mode) or toggles a free-running cadence (run mode).
module fir_sample_source #(
  parameter int DATA_W          = 8,
  parameter int DEPTH           = 16,
  parameter int AMPL            = 100,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RATE            = 50000
) (
  input  logic                     CLOCK_50,
  input  logic                     rst_n,
  input  logic                     toggleBtn,
  input  logic                     mode,
  input  logic                     sample_ready,
  output logic [DATA_W-1:0]        sample_data,
  output logic                     sample_valid,
  output logic [$clog2(DEPTH)-1:0] sample_idx,
  output logic                     wrap,
  output logic                     LEDG
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RT_W  = (RATE > 1) ? $clog2(RATE) : 1;

  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RT_W-1:0]   RT_LOAD = RT_W'(RATE - 1);
  localparam logic [DATA_W-1:0] AMPL_T  = DATA_W'(AMPL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_WAIT
  } state_e;

  // First half of the table holds AMPL, second half is zero; MSB of the index selects.
  function automatic logic [DATA_W-1:0] table_at(input logic [IDX_W-1:0] i);
    return i[IDX_W-1] ? '0 : AMPL_T;
  endfunction

  logic [1:0]        sync_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              clean_q, clean_d;
  logic              clean_dly_q;
  logic              press_q;
  logic              run_q, run_d;

  state_e            state_q, state_d;
  logic [RT_W-1:0]   rate_q, rate_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wrap_q, wrap_d;

  always_comb begin
    db_cnt_d = '0;
    clean_d  = clean_q;
    if (sync_q[1] != clean_q) begin
      if (db_cnt_q == DB_LAST) begin
        clean_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign run_d = mode ? (run_q ^ press_q) : 1'b0;

  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    data_d  = data_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((press_q && !mode) || run_q) begin
          state_d = S_PRESENT;
          valid_d = 1'b1;
          data_d  = table_at(idx_q);
        end
      end
      S_PRESENT: begin
        if (sample_ready) begin
          idx_d   = idx_q + IDX_W'(1);
          wrap_d  = (idx_q == '1);
          valid_d = 1'b0;
          if (run_q) begin
            state_d = S_WAIT;
            rate_d  = RT_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (rate_q == '0) begin
          if (run_q) begin
            state_d = S_PRESENT;
            valid_d = 1'b1;
            data_d  = table_at(idx_q);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          rate_d = rate_q - RT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      db_cnt_q    <= '0;
      clean_q     <= 1'b0;
      clean_dly_q <= 1'b0;
      press_q     <= 1'b0;
      run_q       <= 1'b0;
      state_q     <= S_IDLE;
      rate_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      wrap_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], toggleBtn};
      db_cnt_q    <= db_cnt_d;
      clean_q     <= clean_d;
      clean_dly_q <= clean_q;
      press_q     <= clean_q & ~clean_dly_q;
      run_q       <= run_d;
      state_q     <= state_d;
      rate_q      <= rate_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      idx_q       <= idx_d;
      wrap_q      <= wrap_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign sample_idx   = idx_q;
  assign wrap         = wrap_q;
  assign LEDG         = run_q;

endmodule

// File: tb/tb_fir_sample_source.sv
// Directed bench for fir_sample_source with a scoreboard of expected samples.
module tb_fir_sample_source;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       toggleBtn;
  logic       mode;
  logic       sample_ready;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic [2:0] sample_idx;
  logic       wrap;
  logic       LEDG;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_idx  = 0;
  int   wrap_seen = 0;
  logic pending_wrap = 1'b0;
  int   c, vcount, first_v, w0;

  fir_sample_source #(
    .DATA_W(8),
    .DEPTH(8),
    .AMPL(100),
    .DEBOUNCE_CYCLES(4),
    .RATE(3)
  ) dut (
    .CLOCK_50(clk),
    .rst_n(rst_n),
    .toggleBtn(toggleBtn),
    .mode(mode),
    .sample_ready(sample_ready),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .sample_idx(sample_idx),
    .wrap(wrap),
    .LEDG(LEDG)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tbl(input int i);
    return (i < 4) ? 8'd100 : 8'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_exp();
    exp_t x;
    logic [2:0] i3;
    i3 = 3'(exp_idx);
    x.data = tbl(exp_idx);
    x.idx  = i3;
    sb.push_back(x);
    exp_idx = (exp_idx + 1) % 8;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max; i++) begin
      step(1);
      if (sample_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check("valid_timeout", 32'(sample_valid), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    exp_idx = 0;
  endtask

  task automatic count_valids(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (sample_valid === 1'b1) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    toggleBtn    = 1'b0;
    mode         = 1'b0;
    sample_ready = 1'b0;

    // Acceptance monitor: pops the scoreboard and tracks the expected wrap pulse.
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          pending_wrap = 1'b0;
        end else begin
          check("wrap", 32'(wrap), 32'(pending_wrap));
          if (wrap === 1'b1) wrap_seen++;
          pending_wrap = 1'b0;
          if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
            check("unexpected_valid", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check("sb_data", 32'(sample_data), 32'(e.data));
              check("sb_idx", 32'(sample_idx), 32'(e.idx));
              pending_wrap = (e.idx == 3'd7);
            end
          end
        end
      end
    join_none

    // Reset values
    step(2);
    check("rst_data", 32'(sample_data), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_idx", 32'(sample_idx), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_ledg", 32'(LEDG), 0);
    rst_n = 1'b1;
    step(1);

    // Single press, step mode: valid exactly in cycle 8 for one cycle
    mode = 1'b0;
    sample_ready = 1'b1;
    push_exp();
    toggleBtn = 1'b1;
    vcount = 0;
    first_v = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (sample_valid === 1'b1) begin
        vcount++;
        if (first_v == 0) first_v = k;
      end
    end
    check("press_latency", first_v, 8);
    check("press_valid_cycles", vcount, 1);
    check("idx_after_press", 32'(sample_idx), 1);
    check("ledg_step", 32'(LEDG), 0);
    toggleBtn = 1'b0;
    step(12);
    check("sb_empty_1", sb.size(), 0);

    // Glitch rejection
    do_reset();
    toggleBtn = 1'b1;
    step(3);
    toggleBtn = 1'b0;
    count_valids(15, vcount);
    check("glitch_valids", vcount, 0);
    check("glitch_idx", 32'(sample_idx), 0);

    // Backpressure with a dropped press during the stall
    do_reset();
    sample_ready = 1'b0;
    push_exp();
    toggleBtn = 1'b1;
    wait_valid(20, c);
    check("bp_latency", c, 8);
    toggleBtn = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (i == 8) toggleBtn = 1'b1;
      check("bp_valid_hold", 32'(sample_valid), 1);
      check("bp_data_hold", 32'(sample_data), 100);
      check("bp_idx_hold", 32'(sample_idx), 0);
    end
    sample_ready = 1'b1;
    step(1);
    check("bp_valid_drop", 32'(sample_valid), 0);
    check("bp_idx_after", 32'(sample_idx), 1);
    toggleBtn = 1'b0;
    count_valids(20, vcount);
    check("bp_dropped_press", vcount, 0);
    check("sb_empty_3", sb.size(), 0);

    // Run mode cadence, table sequence and wrap
    do_reset();
    mode = 1'b1;
    sample_ready = 1'b1;
    w0 = wrap_seen;
    for (int s = 0; s < 9; s++) push_exp();
    toggleBtn = 1'b1;
    wait_valid(30, c);
    check("run_ledg", 32'(LEDG), 1);
    toggleBtn = 1'b0;
    for (int s = 1; s < 9; s++) begin
      wait_valid(10, c);
      check("run_period", c, 4);
    end
    step(1);
    sample_ready = 1'b0;
    push_exp();
    wait_valid(10, c);
    check("run_period_last", c, 3);
    check("run_ledg_still", 32'(LEDG), 1);

    // Stop during present: press clears run while the sample is stalled
    toggleBtn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("stop_valid_hold", 32'(sample_valid), 1);
    end
    check("stop_ledg", 32'(LEDG), 0);
    toggleBtn = 1'b0;
    sample_ready = 1'b1;
    step(1);
    check("stop_valid_drop", 32'(sample_valid), 0);
    check("stop_idx", 32'(sample_idx), 2);
    count_valids(20, vcount);
    check("stop_no_more", vcount, 0);
    check("run_wrap_count", wrap_seen - w0, 1);
    check("sb_empty_5", sb.size(), 0);

    // Reset while presenting index 5
    do_reset();
    mode = 1'b1;
    sample_ready = 1'b1;
    for (int s = 0; s < 5; s++) push_exp();
    toggleBtn = 1'b1;
    wait_valid(30, c);
    toggleBtn = 1'b0;
    for (int s = 1; s < 5; s++) wait_valid(10, c);
    step(1);
    sample_ready = 1'b0;
    wait_valid(10, c);
    check("mid_idx5", 32'(sample_idx), 5);
    check("mid_data5", 32'(sample_data), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(sample_valid), 0);
    check("mid_rst_data", 32'(sample_data), 0);
    check("mid_rst_idx", 32'(sample_idx), 0);
    check("mid_rst_wrap", 32'(wrap), 0);
    check("mid_rst_ledg", 32'(LEDG), 0);
    step(2);
    rst_n = 1'b1;
    mode = 1'b0;
    sample_ready = 1'b1;
    exp_idx = 0;
    step(1);
    push_exp();
    toggleBtn = 1'b1;
    wait_valid(20, c);
    check("post_rst_idx", 32'(sample_idx), 0);
    check("post_rst_data", 32'(sample_data), 100);
    step(3);
    toggleBtn = 1'b0;
    step(12);
    check("sb_empty_6", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
